alu_muldiv_sequencer: RTL and testbench
=======================================

Name: alu_muldiv_sequencer

Overview:
Multi-cycle controller that performs 64-bit MUL (low 64 bits of the product) and DIVU/REMU by sequencing the shared 64-bit ALU one step per cycle. MUL uses shift-add; DIVU uses restoring division. The block owns the ALU operand/operation inputs while busy. It sits beside the ALU in the execute stage and serves M-extension instructions with a start/busy/done handshake.

Parameters:
MUL_EARLY_EXIT, 0, when 1 a MUL finishes as soon as the remaining multiplier is zero.
ALU_ADD, 4'b0010, ALU Operation code for add.
ALU_SUB, 4'b0110, ALU Operation code for subtract.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = MUL, 1 = DIVU
opa  input  64  multiplicand / dividend
opb  input  64  multiplier / divisor
busy  output  1  high in MUL_STEP/DIV_STEP
done  output  1  one-cycle pulse; results are valid from this cycle on
result_lo  output  64  product low word / quotient
result_hi  output  64  0 for MUL / remainder for DIVU
div_by_zero  output  1  set with done when DIVU had opb == 0
alu_a  output  64  ALU A operand
alu_b  output  64  ALU B operand
alu_op  output  4  ALU Operation
alu_result  input  64  ALU Result (combinational from alu_a/alu_b/alu_op)

Behaviour:
- States: IDLE, MUL_STEP, DIV_STEP, DONE. Internal regs: acc, mcand, mplier, rem, quo, divisor, 7-bit step counter cnt.
- Reset: state=IDLE. busy, done, div_by_zero = 0. result_lo, result_hi = 0. All internal regs = 0. Reset has priority over everything and aborts any operation in progress; no done is produced.
- IDLE:
  - alu_a = 0, alu_b = 0, alu_op = ALU_ADD.
  - start=1, op=0: acc=0, mcand=opa, mplier=opb, cnt=0, go to MUL_STEP.
  - start=1, op=1, opb!=0: rem=0, quo=opa, divisor=opb, cnt=0, go to DIV_STEP.
  - start=1, op=1, opb==0: result_lo=all ones, result_hi=opa, div_by_zero=1, go to DONE.
- MUL_STEP:
  - alu_a=acc, alu_b=mcand, alu_op=ALU_ADD.
  - If mplier[0]=1, acc<=alu_result; otherwise acc holds.
  - mcand<<=1, mplier>>=1, cnt++.
  - Exit to DONE after cnt reaches 63, or after the current step if MUL_EARLY_EXIT=1 and (mplier>>1)==0.
  - On exit: result_lo = final acc, result_hi = 0.
  - Arithmetic is mod 2^64; overflow is discarded silently.
- DIV_STEP:
  - sh = {rem[62:0], quo[63]}; c = rem[63] (the shifted-out bit).
  - alu_a=sh, alu_b=divisor, alu_op=ALU_SUB.
  - ltu = (~sh[63] & divisor[63]) | (~(sh[63]^divisor[63]) & alu_result[63]).
  - If c | ~ltu: rem<=alu_result, quo<={quo[62:0],1}. Else: rem<=sh, quo<={quo[62:0],0}.
  - cnt++. After the step with cnt==63, go to DONE with result_lo=final quo, result_hi=final rem, div_by_zero=0.
- DONE:
  - done=1 for exactly this cycle; alu outputs as in IDLE; next state IDLE.
- Results and div_by_zero hold until the next accepted start overwrites them at completion.
- Latency: start sampled in cycle T gives done in T+65 (full MUL/DIVU) and T+1 for divide-by-zero. With MUL_EARLY_EXIT=1, MUL takes T+1+k cycles, where k = 1..64 is the index of the highest set multiplier bit plus one; opb==0 counts as k=1.
- start while busy or in DONE is ignored, not queued. A new start is accepted only in IDLE.
- Ownership: the ALU is owned by this block only while busy. Outside busy it presents add of zeros; external muxing is the integrator's responsibility.

Test Plan:
- MUL 7 x 6, start at T -> busy high T+1..T+64, done at T+65, result_lo=42, result_hi=0.
- MUL 0xFFFF_FFFF_FFFF_FFFF x 2 -> result_lo=0xFFFF_FFFF_FFFF_FFFE (wrap); with MUL_EARLY_EXIT=1, MUL 5 x 3 -> done at T+3, result_lo=15.
- DIVU 100 / 7 -> result_lo=14, result_hi=2, div_by_zero=0, done at T+65.
- DIVU 0x8000_0000_0000_0000 / 3 -> result_lo=0x2AAA_AAAA_AAAA_AAAA, result_hi=2. DIVU 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0001 -> quotient 1, remainder 0x7FFF_FFFF_FFFF_FFFE (exercises the c/ltu path).
- DIVU 5 / 0 -> done at T+1, result_lo=0xFFFF_FFFF_FFFF_FFFF, result_hi=5, div_by_zero=1.
- Reset at step 30 of a MUL -> next cycle busy=0, done=0, results=0, no done later. start pulsed during busy -> ignored, first result unchanged, single done pulse.

Source files
------------

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL (low 64 bits) and DIVU/REMU controller that drives a shared
// 64-bit ALU one step per cycle: shift-add multiply, restoring division.
module alu_muldiv_sequencer #(
    parameter bit         MUL_EARLY_EXIT = 1'b0,
    parameter logic [3:0] ALU_ADD        = 4'b0010,
    parameter logic [3:0] ALU_SUB        = 4'b0110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic        busy,
    output logic        done,
    output logic [63:0] result_lo,
    output logic [63:0] result_hi,
    output logic        div_by_zero,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result
);

    // state    | meaning
    // IDLE     | waiting for start; ALU presented add of zeros
    // MUL_STEP | one shift-add step per cycle, acc += mcand when mplier[0]
    // DIV_STEP | one restoring-division step per cycle
    // DONE     | single-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, MUL_STEP, DIV_STEP, DONE} state_t;

    state_t      state;
    logic [63:0] acc, mcand, mplier;
    logic [63:0] rem, quo, divisor;
    logic [6:0]  cnt;

    logic [63:0] sh;
    logic        c, ltu, div_ge;
    logic [63:0] acc_next, rem_next, quo_next;
    logic        mul_last, step_last;

    // Unsigned sh < divisor recovered from the sign of sh - divisor.
    assign sh        = {rem[62:0], quo[63]};
    assign c         = rem[63];
    assign ltu       = (~sh[63] & divisor[63]) | (~(sh[63] ^ divisor[63]) & alu_result[63]);
    assign div_ge    = c | ~ltu;
    assign rem_next  = div_ge ? alu_result : sh;
    assign quo_next  = {quo[62:0], div_ge};
    assign acc_next  = mplier[0] ? alu_result : acc;
    assign step_last = (cnt == 7'd63);
    assign mul_last  = step_last || (MUL_EARLY_EXIT && (mplier[63:1] == 63'd0));

    always_comb begin
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        alu_op = ALU_ADD;
        case (state)
            MUL_STEP: begin
                alu_a = acc;
                alu_b = mcand;
            end
            DIV_STEP: begin
                alu_a  = sh;
                alu_b  = divisor;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result_lo   <= 64'd0;
            result_hi   <= 64'd0;
            acc         <= 64'd0;
            mcand       <= 64'd0;
            mplier      <= 64'd0;
            rem         <= 64'd0;
            quo         <= 64'd0;
            divisor     <= 64'd0;
            cnt         <= 7'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= 7'd0;
                        if (!op) begin
                            acc    <= 64'd0;
                            mcand  <= opa;
                            mplier <= opb;
                            busy   <= 1'b1;
                            state  <= MUL_STEP;
                        end else if (opb != 64'd0) begin
                            rem     <= 64'd0;
                            quo     <= opa;
                            divisor <= opb;
                            busy    <= 1'b1;
                            state   <= DIV_STEP;
                        end else begin
                            result_lo   <= '1;
                            result_hi   <= opa;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                MUL_STEP: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 7'd1;
                    if (mul_last) begin
                        result_lo   <= acc_next;
                        result_hi   <= 64'd0;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DIV_STEP: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 7'd1;
                    if (step_last) begin
                        result_lo   <= quo_next;
                        result_hi   <= rem_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Randomized and directed bench for alu_muldiv_sequencer against an arithmetic
// reference (a*b, a/b, a%b) with an ALU model hooked to each instance.
module tb_alu_muldiv_sequencer;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        reset;
    logic        op;
    logic [63:0] opa, opb;
    logic        start0, start1;

    logic        busy0, done0, dz0, busy1, done1, dz1;
    logic [63:0] lo0, hi0, lo1, hi1;
    logic [63:0] aa0, ab0, ar0, aa1, ab1, ar1;
    logic [3:0]  ao0, ao1;

    int passed = 0;
    int total  = 0;
    bit sel;

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [3:0] o);
        if (o == ADD) return a + b;
        if (o == SUB) return a - b;
        return 64'd0;
    endfunction

    assign ar0 = alu_model(aa0, ab0, ao0);
    assign ar1 = alu_model(aa1, ab1, ao1);

    alu_muldiv_sequencer #(.MUL_EARLY_EXIT(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start0), .op(op), .opa(opa), .opb(opb),
        .busy(busy0), .done(done0), .result_lo(lo0), .result_hi(hi0), .div_by_zero(dz0),
        .alu_a(aa0), .alu_b(ab0), .alu_op(ao0), .alu_result(ar0));

    alu_muldiv_sequencer #(.MUL_EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .reset(reset), .start(start1), .op(op), .opa(opa), .opb(opb),
        .busy(busy1), .done(done1), .result_lo(lo1), .result_hi(hi1), .div_by_zero(dz1),
        .alu_a(aa1), .alu_b(ab1), .alu_op(ao1), .alu_result(ar1));

    wire        s_busy = sel ? busy1 : busy0;
    wire        s_done = sel ? done1 : done0;
    wire        s_dz   = sel ? dz1 : dz0;
    wire [63:0] s_lo   = sel ? lo1 : lo0;
    wire [63:0] s_hi   = sel ? hi1 : hi0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation to completion on the selected instance and checks it.
    task automatic run_op(input bit ee, input bit o, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] e_lo, e_hi;
        logic        e_dz;
        int          e_lat, lat, nbusy, k;
        if (o && b == 64'd0) begin
            e_lo = '1; e_hi = a; e_dz = 1'b1; e_lat = 1;
        end else if (o) begin
            e_lo = a / b; e_hi = a % b; e_dz = 1'b0; e_lat = 65;
        end else begin
            e_lo = a * b; e_hi = 64'd0; e_dz = 1'b0; e_lat = 65;
            if (ee) begin
                k = 1;
                for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
                e_lat = 1 + k;
            end
        end
        @(negedge clk);
        sel = ee; op = o; opa = a; opb = b;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        lat = 1; nbusy = 0;
        while (!s_done && lat < 200) begin
            if (s_busy) nbusy++;
            tick();
            lat++;
        end
        chk($sformatf("%s latency", o ? "div" : "mul"), 64'(lat), 64'(e_lat));
        chk("busy cycles", 64'(nbusy), 64'(e_lat - 1));
        chk($sformatf("result_lo %h op %h", a, b), s_lo, e_lo);
        chk($sformatf("result_hi %h op %h", a, b), s_hi, e_hi);
        chk("div_by_zero", 64'(s_dz), 64'(e_dz));
        tick();
        chk("done one cycle", 64'(s_done), 64'd0);
        chk("result held", s_lo, e_lo);
        tick();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int npulse;
        logic [63:0] a, b;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; op = 1'b0; opa = '0; opb = '0; sel = 1'b0;
        repeat (3) tick();
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset lo", lo0, 64'd0);
        chk("reset hi", hi0, 64'd0);
        chk("reset dz", 64'(dz0), 64'd0);
        chk("idle alu_a", aa0, 64'd0);
        chk("idle alu_b", ab0, 64'd0);
        chk("idle alu_op", 64'(ao0), 64'(ADD));
        @(negedge clk);
        reset = 1'b0;
        tick();

        run_op(0, 0, 64'd7, 64'd6);
        run_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(1, 0, 64'd5, 64'd3);
        run_op(1, 0, 64'd9, 64'd0);
        run_op(1, 0, 64'd3, 64'h8000_0000_0000_0000);
        run_op(0, 1, 64'd100, 64'd7);
        run_op(0, 1, 64'h8000_0000_0000_0000, 64'd3);
        run_op(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
        run_op(0, 1, 64'd5, 64'd0);
        run_op(0, 0, 64'd11, 64'd13);
        chk("mul after dz clears flag", 64'(dz0), 64'd0);
        chk("idle alu_op after ops", 64'(ao0), 64'(ADD));

        for (int i = 0; i < 24; i++) begin
            a = rnd64();
            b = rnd64() >> $urandom_range(63, 0);
            if ($urandom_range(7, 0) == 0) b = 64'd0;
            run_op(0, 1, a, b);
            run_op(0, 0, a, b);
            run_op(1, 0, rnd64(), b);
            if ($urandom_range(1, 0) == 1) run_op(0, 1, a, a >> $urandom_range(3, 0));
        end

        // Reset mid-MUL aborts with no done.
        @(negedge clk);
        sel = 0; op = 0; opa = 64'd7; opb = 64'd6; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (29) tick();
        chk("busy at step 30", 64'(busy0), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("abort busy", 64'(busy0), 64'd0);
        chk("abort done", 64'(done0), 64'd0);
        chk("abort lo", lo0, 64'd0);
        chk("abort hi", hi0, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        npulse = 0;
        repeat (80) begin
            tick();
            if (done0) npulse++;
        end
        chk("no done after abort", 64'(npulse), 64'd0);

        // Start pulsed while busy is ignored.
        @(negedge clk);
        op = 0; opa = 64'd7; opb = 64'd6; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        npulse = 0;
        repeat (10) tick();
        @(negedge clk);
        op = 1; opa = 64'd100; opb = 64'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (80) begin
            tick();
            if (done0) npulse++;
        end
        chk("single done pulse", 64'(npulse), 64'd1);
        chk("ignored start lo", lo0, 64'd42);
        chk("ignored start hi", hi0, 64'd0);
        chk("ignored start dz", 64'(dz0), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
